// File: rtl/game_sequencer_if.sv
// Game controller bus: pulse inputs from the game logic and the registered
// fleet/score/lives view consumed by the renderer and overlay.
interface game_sequencer_if;
  logic        tick;
  logic        fire;
  logic        killingAlien;
  logic [4:0]  alienIndex;
  logic        shipHit;
  logic [2:0]  state;
  logic        playing;
  logic [9:0]  fleetX;
  logic [9:0]  fleetY;
  logic [31:0] aliveMask;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [3:0]  wave;

  modport master (
    output tick, fire, killingAlien, alienIndex, shipHit,
    input  state, playing, fleetX, fleetY, aliveMask, score, lives, wave
  );

  modport slave (
    input  tick, fire, killingAlien, alienIndex, shipHit,
    output state, playing, fleetX, fleetY, aliveMask, score, lives, wave
  );
endinterface

// File: rtl/game_sequencer.sv
// SpaceInvaders game controller: phase FSM, zig-zag fleet stepping, alien
// alive mask, BCD score, lives and wave counter. All outputs are registered.
module game_sequencer #(
  parameter int unsigned X_START     = 16,
  parameter int unsigned X_MIN       = 16,
  parameter int unsigned X_MAX       = 368,
  parameter int unsigned STEP_X      = 4,
  parameter int unsigned Y_START     = 48,
  parameter int unsigned STEP_DOWN   = 16,
  parameter int unsigned Y_LIMIT     = 400,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned PAUSE_TICKS = 100
) (
  input logic              clk,
  input logic              reset,
  game_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StPlay      = 3'd1,
    StRespawn   = 3'd2,
    StWaveClear = 3'd3,
    StGameOver  = 3'd4
  } state_e;

  localparam int unsigned PauseW = $clog2(PAUSE_TICKS + 1);

  localparam logic [9:0]        XStart    = 10'(X_START);
  localparam logic [9:0]        YStart    = 10'(Y_START);
  localparam logic [9:0]        StepX     = 10'(STEP_X);
  localparam logic [9:0]        StepDown  = 10'(STEP_DOWN);
  localparam logic [9:0]        YLimit    = 10'(Y_LIMIT);
  // Bounce tests are done one bit wider so fleetX + STEP_X cannot wrap.
  localparam logic [10:0]       StepXW    = 11'(STEP_X);
  localparam logic [10:0]       XMaxW     = 11'(X_MAX);
  localparam logic [10:0]       XMinStepW = 11'(X_MIN + STEP_X);
  localparam logic [1:0]        LivesInit = 2'(LIVES);
  localparam logic [PauseW-1:0] PauseLast = PauseW'(PAUSE_TICKS - 1);

  state_e              state_q, state_d;
  logic                playing_q, playing_d;
  logic [9:0]          fleet_x_q, fleet_x_d;
  logic [9:0]          fleet_y_q, fleet_y_d;
  logic                dir_left_q, dir_left_d;
  logic [31:0]         mask_q, mask_d;
  logic [15:0]         score_q, score_d;
  logic [1:0]          lives_q, lives_d;
  logic [3:0]          wave_q, wave_d;
  logic [PauseW-1:0]   pause_q, pause_d;

  // Add 10 to a 4-digit BCD score whose ones digit is always 0, saturating at 9990.
  function automatic logic [15:0] bcd_add_ten(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    if (s >= 16'h9990) begin
      r = 16'h9990;
    end else if (s[7:4] != 4'd9) begin
      r[7:4] = s[7:4] + 4'd1;
    end else begin
      r[7:4] = 4'd0;
      if (s[11:8] != 4'd9) begin
        r[11:8] = s[11:8] + 4'd1;
      end else begin
        r[11:8]  = 4'd0;
        r[15:12] = s[15:12] + 4'd1;
      end
    end
    return r;
  endfunction

  // Next-state and datapath updates for every game phase.
  always_comb begin
    state_d    = state_q;
    fleet_x_d  = fleet_x_q;
    fleet_y_d  = fleet_y_q;
    dir_left_d = dir_left_q;
    mask_d     = mask_q;
    score_d    = score_q;
    lives_d    = lives_q;
    wave_d     = wave_q;
    pause_d    = pause_q;

    unique case (state_q)
      StIdle: begin
        if (bus.fire) begin
          state_d    = StPlay;
          score_d    = '0;
          lives_d    = LivesInit;
          wave_d     = '0;
          mask_d     = '1;
          fleet_x_d  = XStart;
          fleet_y_d  = YStart;
          dir_left_d = 1'b0;
        end
      end

      StPlay: begin
        if (bus.tick) begin
          if (!dir_left_q) begin
            if (({1'b0, fleet_x_q} + StepXW) > XMaxW) begin
              dir_left_d = 1'b1;
              fleet_y_d  = fleet_y_q + StepDown;
            end else begin
              fleet_x_d = fleet_x_q + StepX;
            end
          end else begin
            if ({1'b0, fleet_x_q} < XMinStepW) begin
              dir_left_d = 1'b0;
              fleet_y_d  = fleet_y_q + StepDown;
            end else begin
              fleet_x_d = fleet_x_q - StepX;
            end
          end
        end

        // Kills of already-dead aliens score nothing.
        if (bus.killingAlien && mask_q[bus.alienIndex]) begin
          mask_d[bus.alienIndex] = 1'b0;
          score_d                = bcd_add_ten(score_q);
        end

        // Transitions look at the already-updated fleet and mask.
        if (bus.shipHit && (lives_q == 2'd1)) begin
          state_d = StGameOver;
          lives_d = '0;
        end else if (bus.shipHit && (lives_q > 2'd1)) begin
          state_d = StRespawn;
          lives_d = lives_q - 2'd1;
          pause_d = '0;
        end else if (fleet_y_d >= YLimit) begin
          state_d = StGameOver;
        end else if (mask_d == '0) begin
          state_d = StWaveClear;
          pause_d = '0;
        end
      end

      StRespawn: begin
        if (bus.tick) begin
          if (pause_q == PauseLast) begin
            pause_d = '0;
            state_d = (mask_q == '0) ? StWaveClear : StPlay;
          end else begin
            pause_d = pause_q + 1'b1;
          end
        end
      end

      StWaveClear: begin
        if (bus.tick) begin
          if (pause_q == PauseLast) begin
            pause_d    = '0;
            state_d    = StPlay;
            mask_d     = '1;
            fleet_x_d  = XStart;
            fleet_y_d  = YStart;
            dir_left_d = 1'b0;
            wave_d     = wave_q + 4'd1;
          end else begin
            pause_d = pause_q + 1'b1;
          end
        end
      end

      StGameOver: begin
        if (bus.fire) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    playing_d = (state_d == StPlay);
  end

  // State and datapath registers; reset drops straight back to the attract state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      playing_q  <= 1'b0;
      fleet_x_q  <= XStart;
      fleet_y_q  <= YStart;
      dir_left_q <= 1'b0;
      mask_q     <= '1;
      score_q    <= '0;
      lives_q    <= LivesInit;
      wave_q     <= '0;
      pause_q    <= '0;
    end else begin
      state_q    <= state_d;
      playing_q  <= playing_d;
      fleet_x_q  <= fleet_x_d;
      fleet_y_q  <= fleet_y_d;
      dir_left_q <= dir_left_d;
      mask_q     <= mask_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      wave_q     <= wave_d;
      pause_q    <= pause_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.playing   = playing_q;
  assign bus.fleetX    = fleet_x_q;
  assign bus.fleetY    = fleet_y_q;
  assign bus.aliveMask = mask_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.wave      = wave_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed vector table, hand-written
// phase sequences and randomized play, all checked against a behavioural model.
module tb_game_sequencer;

  logic clk;
  logic reset;

  game_sequencer_if bus ();

  game_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared;
  int nMismatched;

  // Behavioural model: plain integers, decimal score.
  int          mState;
  int          mX;
  int          mY;
  logic [31:0] mMask;
  int          mScore;
  int          mLives;
  int          mWave;
  bit          mRight;
  int          mPause;

  typedef struct {
    bit          tk;
    bit          fr;
    bit          kl;
    int          idx;
    bit          ht;
    int          expState;
    logic [31:0] expMask;
    logic [15:0] expScore;
    int          expLives;
    int          expX;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mState = 0; mX = 16; mY = 48; mMask = '1; mScore = 0;
    mLives = 3; mWave = 0; mRight = 1'b1; mPause = 0;
  endtask

  task automatic model_step(input bit tk, input bit fr, input bit kl, input int idx, input bit ht);
    case (mState)
      0: if (fr) begin
        mState = 1; mScore = 0; mLives = 3; mWave = 0; mMask = '1;
        mX = 16; mY = 48; mRight = 1'b1;
      end
      1: begin
        if (tk) begin
          if (mRight) begin
            if (mX + 4 > 368) begin mRight = 1'b0; mY += 16; end
            else mX += 4;
          end else begin
            if (mX < 16 + 4) begin mRight = 1'b1; mY += 16; end
            else mX -= 4;
          end
        end
        if (kl && mMask[idx]) begin
          mMask[idx] = 1'b0;
          mScore = (mScore + 10 > 9990) ? 9990 : mScore + 10;
        end
        if (ht && mLives == 1) begin mState = 4; mLives = 0; end
        else if (ht && mLives > 1) begin mState = 2; mLives -= 1; mPause = 0; end
        else if (mY >= 400) mState = 4;
        else if (mMask == 0) begin mState = 3; mPause = 0; end
      end
      2: if (tk) begin
        mPause++;
        if (mPause == 100) begin
          mPause = 0;
          mState = (mMask == 0) ? 3 : 1;
        end
      end
      3: if (tk) begin
        mPause++;
        if (mPause == 100) begin
          mPause = 0; mState = 1; mMask = '1; mX = 16; mY = 48; mRight = 1'b1;
          mWave = (mWave + 1) % 16;
        end
      end
      4: if (fr) mState = 0;
      default: ;
    endcase
  endtask

  task automatic check_model();
    chk("state", 32'(bus.state), mState);
    chk("playing", 32'(bus.playing), 32'(mState == 1));
    chk("fleetX", 32'(bus.fleetX), mX);
    chk("fleetY", 32'(bus.fleetY), mY);
    chk("aliveMask", bus.aliveMask, mMask);
    chk("score", 32'(bus.score), 32'(to_bcd(mScore)));
    chk("lives", 32'(bus.lives), mLives);
    chk("wave", 32'(bus.wave), mWave);
  endtask

  // One clock with the given pulses, then model update and full comparison.
  task automatic step(input bit tk, input bit fr, input bit kl, input int idx, input bit ht);
    bus.tick = tk; bus.fire = fr; bus.killingAlien = kl;
    bus.alienIndex = 5'(idx); bus.shipHit = ht;
    @(posedge clk);
    #1;
    bus.tick = 1'b0; bus.fire = 1'b0; bus.killingAlien = 1'b0; bus.shipHit = 1'b0;
    model_step(tk, fr, kl, idx, ht);
    check_model();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".state"}, 32'(bus.state), 0);
    chk({tag, ".playing"}, 32'(bus.playing), 0);
    chk({tag, ".fleetX"}, 32'(bus.fleetX), 16);
    chk({tag, ".fleetY"}, 32'(bus.fleetY), 48);
    chk({tag, ".mask"}, bus.aliveMask, 32'hFFFF_FFFF);
    chk({tag, ".score"}, 32'(bus.score), 0);
    chk({tag, ".lives"}, 32'(bus.lives), 3);
    chk({tag, ".wave"}, 32'(bus.wave), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nCompared = 0;
    nMismatched = 0;
    bus.tick = 1'b0; bus.fire = 1'b0; bus.killingAlien = 1'b0;
    bus.alienIndex = '0; bus.shipHit = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk_reset_values("reset");

    // Directed vector table: tk fr kl idx ht | state mask score lives fleetX
    vecs.push_back('{0, 1, 0,  0, 0, 1, 32'hFFFF_FFFF, 16'h0000, 3, 16});
    vecs.push_back('{0, 0, 1,  5, 0, 1, 32'hFFFF_FFDF, 16'h0010, 3, 16});
    vecs.push_back('{0, 0, 1,  5, 0, 1, 32'hFFFF_FFDF, 16'h0010, 3, 16});
    vecs.push_back('{1, 0, 1,  5, 0, 1, 32'hFFFF_FFDF, 16'h0010, 3, 20});
    vecs.push_back('{0, 0, 1,  0, 0, 1, 32'hFFFF_FFDE, 16'h0020, 3, 20});
    vecs.push_back('{0, 0, 1,  1, 0, 1, 32'hFFFF_FFDC, 16'h0030, 3, 20});
    vecs.push_back('{0, 0, 0,  0, 1, 2, 32'hFFFF_FFDC, 16'h0030, 2, 20});
    vecs.push_back('{0, 0, 1,  2, 0, 2, 32'hFFFF_FFDC, 16'h0030, 2, 20});
    vecs.push_back('{1, 0, 0,  0, 0, 2, 32'hFFFF_FFDC, 16'h0030, 2, 20});
    vecs.push_back('{0, 1, 0,  0, 1, 2, 32'hFFFF_FFDC, 16'h0030, 2, 20});
    foreach (vecs[i]) begin
      step(vecs[i].tk, vecs[i].fr, vecs[i].kl, vecs[i].idx, vecs[i].ht);
      chk($sformatf("vec%0d.state", i), 32'(bus.state), vecs[i].expState);
      chk($sformatf("vec%0d.mask", i), bus.aliveMask, vecs[i].expMask);
      chk($sformatf("vec%0d.score", i), 32'(bus.score), 32'(vecs[i].expScore));
      chk($sformatf("vec%0d.lives", i), 32'(bus.lives), vecs[i].expLives);
      chk($sformatf("vec%0d.fleetX", i), 32'(bus.fleetX), vecs[i].expX);
    end

    // Respawn pause: one tick already taken, 98 more keep RESPAWN, the 100th resumes.
    repeat (98) step(1, 0, 0, 0, 0);
    chk("respawn.hold", 32'(bus.state), 2);
    step(1, 0, 0, 0, 0);
    chk("respawn.exit", 32'(bus.state), 1);

    // Fleet bounce at the right edge.
    repeat (87) step(1, 0, 0, 0, 0);
    chk("bounce.preX", 32'(bus.fleetX), 368);
    step(1, 0, 0, 0, 0);
    chk("bounce.X", 32'(bus.fleetX), 368);
    chk("bounce.Y", 32'(bus.fleetY), 64);
    step(1, 0, 0, 0, 0);
    chk("bounce.leftX", 32'(bus.fleetX), 364);

    // Wave clear with back-to-back kills.
    for (int i = 0; i < 32; i++) step(0, 0, 1, i, 0);
    chk("clear.state", 32'(bus.state), 3);
    chk("clear.mask", bus.aliveMask, 0);
    chk("clear.score", 32'(bus.score), 32'h0320);
    repeat (99) step(1, 0, 0, 0, 0);
    chk("clear.hold", 32'(bus.state), 3);
    step(1, 0, 0, 0, 0);
    chk("clear.exit", 32'(bus.state), 1);
    chk("clear.newMask", bus.aliveMask, 32'hFFFF_FFFF);
    chk("clear.wave", 32'(bus.wave), 1);
    chk("clear.X", 32'(bus.fleetX), 16);
    chk("clear.Y", 32'(bus.fleetY), 48);

    // Lose a life, then the last kill together with the fatal hit.
    step(0, 0, 0, 0, 1);
    chk("hit.state", 32'(bus.state), 2);
    chk("hit.lives", 32'(bus.lives), 1);
    repeat (100) step(1, 0, 0, 0, 0);
    chk("hit.resume", 32'(bus.state), 1);
    for (int i = 0; i < 31; i++) step(0, 0, 1, i, 0);
    step(0, 0, 1, 31, 1);
    chk("fatal.state", 32'(bus.state), 4);
    chk("fatal.mask", bus.aliveMask, 0);
    chk("fatal.score", 32'(bus.score), 32'h0640);
    chk("fatal.lives", 32'(bus.lives), 0);
    step(1, 0, 1, 3, 1);
    chk("over.hold", 32'(bus.score), 32'h0640);
    step(0, 1, 0, 0, 0);
    chk("over.idle", 32'(bus.state), 0);
    chk("over.keepScore", 32'(bus.score), 32'h0640);
    step(0, 1, 0, 0, 0);
    chk("restart.state", 32'(bus.state), 1);
    chk("restart.score", 32'(bus.score), 0);

    // Fleet invasion: keep ticking until the game ends, bounded.
    for (int n = 0; n < 2500 && bus.state == 3'd1; n++) step(1, 0, 0, 0, 0);
    chk("invade.state", 32'(bus.state), 4);
    chk("invade.Y", 32'(bus.fleetY), 400);
    chk("invade.lives", 32'(bus.lives), 3);

    // Score saturation and wave wrap across 32 cleared waves.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 1024; k++) begin
      step(0, 0, 1, k % 32, 0);
      if (k == 992) chk("wave.15", 32'(bus.wave), 15);
      if (k == 998) chk("score.reach", 32'(bus.score), 32'h9990);
      if (k == 999) chk("score.sat", 32'(bus.score), 32'h9990);
      if (mState == 3) repeat (100) step(1, 0, 0, 0, 0);
    end
    chk("wave.wrap", 32'(bus.wave), 0);
    chk("score.final", 32'(bus.score), 32'h9990);

    // Asynchronous reset in the middle of play.
    step(1, 0, 1, 4, 0);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_values("midReset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 1, 0, 0, 0);
    chk("start.state", 32'(bus.state), 1);
    chk("start.lives", 32'(bus.lives), 3);
    chk("start.mask", bus.aliveMask, 32'hFFFF_FFFF);

    // Randomized play against the model.
    for (int n = 0; n < 3000; n++) begin
      step(bit'($urandom % 2), bit'($urandom % 24 == 0), bit'($urandom % 3 == 0),
           int'($urandom % 32), bit'($urandom % 60 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
